// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
// Module   : alu_md
// Brief    : Execute-stage integer unit. Base ALU ops complete in one cycle;
//            RV32M multiply/divide run on an iterative radix-2 datapath under
//            a SETUP/ITER/FIX sequencer. valid/ready on both sides, flush abort.
// Revision : 1.0 - initial release
// ============================================================================
module alu_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_ITER  = 2'd2,
        S_FIX   = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

    state_t            state, state_nxt;
    logic [SHW-1:0]    cnt;
    logic [2:0]        op_q;          // low bits of the M opcode being iterated
    logic [XLEN-1:0]   opa_q, opb_q;  // raw operands captured at acceptance
    logic [XLEN-1:0]   mcand;         // multiplicand or divisor magnitude
    logic [XLEN-1:0]   hi, lo;        // product high/low, or remainder/quotient
    logic              sign_q;        // negate product / quotient at the end
    logic              sign_r;        // negate remainder at the end

    logic              accept, is_m, div_zero, div_ovf, special;
    logic              start_long, load_quick;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   quick_res, fix_res;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;

    assign in_ready   = (state == S_IDLE) && (!out_valid || out_ready) && !rst && !flush;
    assign busy       = (state != S_IDLE);
    assign accept     = in_valid && in_ready;
    assign is_m       = (aluop[4:3] == 2'b10);
    assign div_zero   = (aluin2 == '0);
    assign div_ovf    = !aluop[0] && (aluin1 == INT_MIN) && (aluin2 == '1);
    // Divide-by-zero and signed overflow have closed-form answers: no iteration.
    assign special    = is_m && aluop[2] && (div_zero || div_ovf);
    assign start_long = accept && is_m && !special;
    assign load_quick = accept && !start_long;
    assign shamt      = aluin2[SHW-1:0];

    // Single-cycle results: base ops, div special cases, illegal codes (zero).
    always_comb begin
        quick_res = '0;
        case (aluop)
            5'h00:   quick_res = aluin1 + aluin2;
            5'h01:   quick_res = aluin1 - aluin2;
            5'h02:   quick_res = aluin1 << shamt;
            5'h03:   quick_res = aluin1 ^ aluin2;
            5'h04:   quick_res = aluin1 >> shamt;
            5'h05:   quick_res = $signed(aluin1) >>> shamt;
            5'h06:   quick_res = aluin1 | aluin2;
            5'h07:   quick_res = aluin1 & aluin2;
            5'h08:   quick_res = {{(XLEN-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
            5'h09:   quick_res = {{(XLEN-1){1'b0}}, (aluin1 < aluin2)};
            5'h14:   quick_res = div_zero ? '1 : aluin1;
            5'h15:   quick_res = '1;
            5'h16:   quick_res = div_zero ? aluin1 : '0;
            5'h17:   quick_res = aluin1;
            default: quick_res = '0;
        endcase
    end

    // Operand signedness per opcode: MULH s*s, MULHSU s*u, DIV/REM signed.
    assign a_sgn = op_q[2] ? !op_q[0] : ((op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10));
    assign b_sgn = op_q[2] ? !op_q[0] : (op_q[1:0] == 2'b01);
    assign a_neg = a_sgn && opa_q[XLEN-1];
    assign b_neg = b_sgn && opb_q[XLEN-1];
    assign mag_a = a_neg ? -opa_q : opa_q;
    assign mag_b = b_neg ? -opb_q : opb_q;

    // One shift-add step ({hi,lo} shifts right) and one restoring-divide step.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand};

    assign prod   = {hi, lo};
    assign prod_s = sign_q ? -prod : prod;

    // Final sign fix-up and half / quotient-remainder selection.
    always_comb begin
        fix_res = '0;
        if (op_q[2]) begin
            if (op_q[1]) fix_res = sign_r ? -hi : hi;
            else         fix_res = sign_q ? -lo : lo;
        end else begin
            if (op_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
            else                    fix_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_long) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_ITER;
            S_ITER:  if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Iterative mul/div datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_long) begin
                        op_q  <= aluop[2:0];
                        opa_q <= aluin1;
                        opb_q <= aluin2;
                    end
                end
                S_SETUP: begin
                    cnt    <= '0;
                    hi     <= '0;
                    sign_q <= a_neg ^ b_neg;
                    sign_r <= a_neg;
                    if (op_q[2]) begin
                        lo    <= mag_a;
                        mcand <= mag_b;
                    end else begin
                        lo    <= mag_b;
                        mcand <= mag_a;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + SHW'(1);
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            hi <= div_diff[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register: loads on a quick result or in FIX, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            aluout    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_quick) begin
            out_valid <= 1'b1;
            aluout    <= quick_res;
        end else if (state == S_FIX) begin
            out_valid <= 1'b1;
            aluout    <= fix_res;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md
// Brief    : Scoreboard bench for alu_md: driver pushes expected results and
//            load-edge offsets; a monitor pops and compares on each consumed
//            output. Directed cases plus randomized ops against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_md;
    localparam int XLEN = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  aluop;
    logic [31:0] aluin1, aluin2, aluout;

    typedef struct {
        logic [31:0] res;
        int          acc;   // clock edge that accepted the request
        int          lat;   // edges from acceptance to the edge loading aluout
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rand_bp = 0;
    bit   seen = 0;

    logic [4:0] ops [0:21] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                               5'h08, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15,
                               5'h16, 5'h17, 5'h0A, 5'h0F, 5'h18, 5'h1F};

    alu_md #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .aluin1(aluin1), .aluin2(aluin2), .out_valid(out_valid),
        .out_ready(out_ready), .aluout(aluout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Reference model written straight from the operation definitions.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a << b[4:0];
            5'h03: return a ^ b;
            5'h04: return a >> b[4:0];
            5'h05: return 32'($signed(a) >>> b[4:0]);
            5'h06: return a | b;
            5'h07: return a & b;
            5'h08: return (sa < sb) ? 32'd1 : 32'd0;
            5'h09: return (a < b) ? 32'd1 : 32'd0;
            5'h10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'h11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            5'h12: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            5'h13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'h14: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            5'h17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Normal M ops take SETUP + XLEN ITER + FIX; everything else loads at acceptance.
    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit m, dv, spec;
        m    = (op >= 5'h10) && (op <= 5'h17);
        dv   = (op >= 5'h14) && (op <= 5'h17);
        spec = dv && ((b == 0) || ((op == 5'h14 || op == 5'h16) && a == INT_MIN && b == 32'hFFFF_FFFF));
        return (m && !spec) ? XLEN + 2 : 0;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input bit rdy_now, output int waited, output int acc);
        exp_t e;
        @(negedge clk);
        aluop = op; aluin1 = a; aluin2 = b; in_valid = 1'b1;
        if (rdy_now) out_ready = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: op %h never accepted", op);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc + 1;
        e.res = expv;
        e.acc = acc;
        e.lat = exp_lat(op, a, b);
        sbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || out_valid) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results still pending", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: handshake rule, latency on first appearance, value on consumption.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst || flush) begin
            seen = 0;
            continue;
        end
        chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!busy && (!out_valid || out_ready))});
        if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: got %h expected none", aluout);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                    seen = 1;
                end
                if (out_ready) begin
                    chk("result", aluout, sbq[0].res);
                    void'(sbq.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial forever begin
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, acc, n;
        logic [4:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; aluin1 = '0; aluin2 = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_aluout", aluout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2 chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

        // Simple ops issued back to back: each must be accepted without waiting.
        issue(5'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, w, acc); chk("b2b_add", 32'(w), 0);
        issue(5'h08, 32'hFFFF_FFFF, 32'h1, 32'h1,         0, w, acc); chk("b2b_slt", 32'(w), 0);
        issue(5'h09, 32'hFFFF_FFFF, 32'h1, 32'h0,         0, w, acc); chk("b2b_sltu", 32'(w), 0);
        issue(5'h05, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, w, acc); chk("b2b_sra", 32'(w), 0);
        issue(5'h02, 32'h1, 32'd33, 32'h2,                0, w, acc); chk("b2b_sll", 32'(w), 0);
        issue(5'h0B, 32'h1234, 32'h5678, 32'h0,           0, w, acc); chk("b2b_illegal", 32'(w), 0);
        wait_drain();

        // Multiplies of all-ones operands.
        issue(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, w, acc);
        issue(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, w, acc);
        issue(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, w, acc);
        issue(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, w, acc);
        wait_drain();

        // Divides, including the closed-form special cases.
        issue(5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, w, acc);
        issue(5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, w, acc);
        issue(5'h15, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, w, acc);
        issue(5'h17, 32'd7, 32'd0, 32'd7, 0, w, acc); chk("b2b_remu0", 32'(w), 0);
        issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, w, acc); chk("b2b_divovf", 32'(w), 0);
        issue(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, w, acc); chk("b2b_removf", 32'(w), 0);
        wait_drain();

        // Backpressure on a DIVU result, then consume and accept in the same cycle.
        @(negedge clk);
        out_ready = 1'b0;
        issue(5'h15, 32'd100, 32'd7, 32'd14, 0, w, acc);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("bp_aluout", aluout, 32'd14);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        issue(5'h00, 32'd10, 32'd20, 32'd30, 1, w, acc); chk("accept_on_consume", 32'(w), 0);
        wait_drain();

        // Flush a MUL at ITER count 10; its result must never appear.
        issue(5'h10, 32'd3, 32'd7, 32'd21, 0, w, acc);
        while (cyc < acc + 11) @(negedge clk);
        flush = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        #2;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        issue(5'h00, 32'd2, 32'd3, 32'd5, 0, w, acc);
        wait_drain();

        // Reset in the middle of a DIV.
        issue(5'h14, 32'd1000, 32'd3, 32'd333, 0, w, acc);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_aluout", aluout, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2 chk("midrst_ready_after", {31'b0, in_ready}, 32'd1);
        issue(5'h03, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0, w, acc);
        wait_drain();

        // Randomized ops with random backpressure against the model.
        rand_bp = 1;
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 21)];
            case ($urandom_range(0, 5))
                0:       a = INT_MIN;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            issue(op, a, b, model(op, a, b), 0, w, acc);
        end
        rand_bp = 0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
